// File: rtl/norm_param_pingpong_buffer_if.sv
// Handshake/bus bundle for the ping-pong normalisation parameter store.
// The master side loads parameters and reads them; the slave side is the buffer.
interface norm_param_pingpong_buffer_if #(
  parameter int WIDTH     = 8,
  parameter int LANES     = 4,
  parameter int ADDR_BITS = 8
);
  logic                   load_start;
  logic                   wr_valid;
  logic [WIDTH-1:0]       wr_data;
  logic                   wr_ready;
  logic                   load_commit;
  logic                   rd_en;
  logic [ADDR_BITS-1:0]   rd_addr;
  logic [WIDTH*LANES-1:0] rd_data;
  logic                   rd_valid;
  logic                   bank_ready;
  logic [ADDR_BITS:0]     load_count;

  modport master (
    output load_start, wr_valid, wr_data, load_commit, rd_en, rd_addr,
    input  wr_ready, rd_data, rd_valid, bank_ready, load_count
  );

  modport slave (
    input  load_start, wr_valid, wr_data, load_commit, rd_en, rd_addr,
    output wr_ready, rd_data, rd_valid, bank_ready, load_count
  );
endinterface

// File: rtl/norm_param_pingpong_buffer.sv
// Double-buffered parameter store: packs LANES narrow words per entry into the
// fill bank while the active bank serves LANES-wide registered reads.
module norm_param_pingpong_buffer #(
  parameter int WIDTH     = 8,
  parameter int LANES     = 4,
  parameter int ADDR_BITS = 8
) (
  input  logic clk,
  input  logic rst_n,
  norm_param_pingpong_buffer_if.slave bus
);
  localparam int DEPTH = 2**ADDR_BITS;
  localparam int LCW   = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;
  typedef logic [LANES-1:0][WIDTH-1:0] entry_t;

  state_t                       state;
  logic                         active, wr_ready, bank_ready, rd_valid;
  logic [LCW-1:0]               lane_cnt;
  logic [ADDR_BITS:0]           waddr, load_count;
  logic [LANES-2:0][WIDTH-1:0]  pack;
  entry_t                       rd_data, cur;
  entry_t                       mem [2][DEPTH];

  logic xfer, last_lane, commit, we;

  assign xfer      = (state == FILL) && bus.wr_valid && wr_ready;
  assign last_lane = (lane_cnt == LCW'(LANES-1));
  assign commit    = bus.load_commit && !bus.load_start && (state != IDLE);
  // Partial entries flush on commit, including a word arriving that same cycle.
  assign we        = (xfer && last_lane) || (commit && (xfer || lane_cnt != '0));

  // Entry under construction: pack register is kept zero above lane_cnt,
  // so unfilled lanes of a flushed partial entry read back as zero.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    if (g < LANES-1) begin : g_packed
      assign cur[g] = (xfer && lane_cnt == LCW'(g)) ? bus.wr_data : pack[g];
    end else begin : g_top
      assign cur[g] = (xfer && last_lane) ? bus.wr_data : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      active     <= 1'b0;
      wr_ready   <= 1'b0;
      bank_ready <= 1'b0;
      load_count <= '0;
      lane_cnt   <= '0;
      waddr      <= '0;
      pack       <= '0;
    end else if (bus.load_start) begin
      state    <= FILL;
      wr_ready <= 1'b1;
      lane_cnt <= '0;
      waddr    <= '0;
      pack     <= '0;
    end else if (commit) begin
      state      <= IDLE;
      wr_ready   <= 1'b0;
      active     <= ~active;
      bank_ready <= 1'b1;
      load_count <= waddr + (ADDR_BITS+1)'(we);
      lane_cnt   <= '0;
      waddr      <= '0;
      pack       <= '0;
    end else if (xfer) begin
      if (last_lane) begin
        lane_cnt <= '0;
        pack     <= '0;
        waddr    <= waddr + (ADDR_BITS+1)'(1);
        if (waddr == (ADDR_BITS+1)'(DEPTH-1)) begin
          state    <= FULL;
          wr_ready <= 1'b0;
        end
      end else begin
        pack     <= cur[LANES-2:0];
        lane_cnt <= lane_cnt + LCW'(1);
      end
    end
  end

  // Distributed RAM, not reset; only the fill bank is ever written.
  always_ff @(posedge clk) begin
    if (we) mem[~active][waddr[ADDR_BITS-1:0]] <= cur;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= bus.rd_en;
      if (bus.rd_en) rd_data <= mem[active][bus.rd_addr];
    end
  end

  assign bus.wr_ready   = wr_ready;
  assign bus.rd_data    = rd_data;
  assign bus.rd_valid   = rd_valid;
  assign bus.bank_ready = bank_ready;
  assign bus.load_count = load_count;
endmodule

// File: tb/tb_norm_param_pingpong_buffer.sv
// Directed bench: default-size buffer for packing/swap/restart/reset cases,
// plus a 4-entry instance for the fill-bank-full case.
module tb_norm_param_pingpong_buffer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  norm_param_pingpong_buffer_if #(.WIDTH(8), .LANES(4), .ADDR_BITS(8)) a();
  norm_param_pingpong_buffer_if #(.WIDTH(8), .LANES(4), .ADDR_BITS(2)) b();

  norm_param_pingpong_buffer #(.WIDTH(8), .LANES(4), .ADDR_BITS(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a.slave));
  norm_param_pingpong_buffer #(.WIDTH(8), .LANES(4), .ADDR_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b.slave));

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    string       name;
    logic [7:0]  addr;
    logic [31:0] exp;
  } rd_vec_t;
  rd_vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a();
    a.load_start = 1'b1; tick(); a.load_start = 1'b0;
  endtask

  task automatic commit_a();
    a.load_commit = 1'b1; tick(); a.load_commit = 1'b0;
  endtask

  task automatic push_a(input logic [7:0] w);
    a.wr_valid = 1'b1; a.wr_data = w; tick(); a.wr_valid = 1'b0;
  endtask

  task automatic read_a(input logic [7:0] addr, output logic [31:0] d, output logic v);
    a.rd_en = 1'b1; a.rd_addr = addr; tick(); a.rd_en = 1'b0;
    d = a.rd_data; v = a.rd_valid;
  endtask

  logic [31:0] d, e;
  logic        v;
  int          acc;

  initial begin
    a.load_start = 0; a.wr_valid = 0; a.wr_data = 0; a.load_commit = 0; a.rd_en = 0; a.rd_addr = 0;
    b.load_start = 0; b.wr_valid = 0; b.wr_data = 0; b.load_commit = 0; b.rd_en = 0; b.rd_addr = 0;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // reset state and an unloaded read
    chk("rst_wr_ready", a.wr_ready, 0);
    chk("rst_bank_ready", a.bank_ready, 0);
    chk("rst_load_count", a.load_count, 0);
    chk("rst_rd_valid", a.rd_valid, 0);
    chk("rst_rd_data", a.rd_data, 0);
    read_a(8'd0, d, v);
    chk("rst_read_valid", v, 1);
    tick();
    chk("rst_read_valid_drop", a.rd_valid, 0);
    commit_a();
    chk("idle_commit_ignored", a.bank_ready, 0);

    // two full entries
    start_a();
    chk("fill_wr_ready", a.wr_ready, 1);
    for (int i = 1; i <= 8; i++) push_a(8'(i));
    commit_a();
    chk("l1_count", a.load_count, 2);
    chk("l1_bank_ready", a.bank_ready, 1);
    chk("l1_wr_ready", a.wr_ready, 0);
    read_a(8'd0, d, v); chk("l1_rd0", d, 32'h04030201);
    read_a(8'd1, d, v); chk("l1_rd1", d, 32'h08070605);

    // commit coinciding with the 4th word, then a 1-word partial
    start_a();
    push_a(8'h11); push_a(8'h12); push_a(8'h13);
    a.wr_valid = 1'b1; a.wr_data = 8'h14; a.load_commit = 1'b1;
    tick();
    a.wr_valid = 1'b0; a.load_commit = 1'b0;
    chk("l2_count", a.load_count, 1);
    read_a(8'd0, d, v); chk("l2_rd0", d, 32'h14131211);
    start_a();
    push_a(8'h21);
    commit_a();
    chk("l3_count", a.load_count, 1);
    read_a(8'd0, d, v); chk("l3_rd0", d, 32'h00000021);

    // table-driven reads after a 10-word load
    start_a();
    for (int i = 0; i < 10; i++) push_a(8'(8'h31 + i));
    commit_a();
    chk("l4_count", a.load_count, 3);
    tbl[0] = '{"t_rd0",  8'd0, 32'h34333231};
    tbl[1] = '{"t_rd1",  8'd1, 32'h38373635};
    tbl[2] = '{"t_rd2",  8'd2, 32'h00003A39};
    tbl[3] = '{"t_rd1b", 8'd1, 32'h38373635};
    tbl[4] = '{"t_rd0b", 8'd0, 32'h34333231};
    for (int i = 0; i < 5; i++) begin
      read_a(tbl[i].addr, d, v);
      chk({tbl[i].name, "_v"}, v, 1);
      chk(tbl[i].name, d, tbl[i].exp);
    end

    // load the other bank while reading the active one every cycle
    for (int k = 0; k < 12; k++) begin
      a.rd_en       = 1'b1;
      a.rd_addr     = 8'(k % 2);
      a.load_start  = (k == 0);
      a.wr_valid    = (k >= 1 && k <= 8);
      a.wr_data     = 8'(8'h40 + k);
      a.load_commit = (k == 9);
      tick();
      if (k <= 9) e = (k % 2 == 0) ? 32'h34333231 : 32'h38373635;
      else        e = (k % 2 == 0) ? 32'h44434241 : 32'h48474645;
      chk($sformatf("sw_v%0d", k), a.rd_valid, 1);
      chk($sformatf("sw_d%0d", k), a.rd_data, e);
    end
    a.rd_en = 0; a.load_start = 0; a.wr_valid = 0; a.load_commit = 0;
    chk("sw_count", a.load_count, 2);

    // restart mid-fill
    start_a();
    for (int i = 0; i < 5; i++) push_a(8'(8'h51 + i));
    start_a();
    for (int i = 0; i < 4; i++) push_a(8'(8'h61 + i));
    commit_a();
    chk("rs_count", a.load_count, 1);
    read_a(8'd0, d, v); chk("rs_rd0", d, 32'h64636261);

    // 4-entry instance: fill to FULL, excess words refused
    b.load_start = 1'b1; tick(); b.load_start = 1'b0;
    acc = 0;
    for (int i = 1; i <= 20; i++) begin
      b.wr_valid = 1'b1; b.wr_data = 8'(i);
      if (b.wr_ready) acc++;
      if (i == 16) chk("b_ready16", b.wr_ready, 1);
      if (i == 17) chk("b_ready17", b.wr_ready, 0);
      tick();
    end
    b.wr_valid = 1'b0;
    chk("b_accepted", acc, 16);
    b.load_commit = 1'b1; tick(); b.load_commit = 1'b0;
    chk("b_count", b.load_count, 4);
    b.rd_en = 1'b1; b.rd_addr = 2'd3; tick(); b.rd_en = 1'b0;
    chk("b_rd3", b.rd_data, 32'h100F0E0D);
    b.rd_en = 1'b1; b.rd_addr = 2'd0; tick(); b.rd_en = 1'b0;
    chk("b_rd0", b.rd_data, 32'h04030201);

    // reset in the middle of a fill
    start_a();
    push_a(8'h71); push_a(8'h72); push_a(8'h73);
    rst_n = 1'b0;
    #2;
    chk("mr_bank_ready", a.bank_ready, 0);
    chk("mr_wr_ready", a.wr_ready, 0);
    chk("mr_load_count", a.load_count, 0);
    tick();
    rst_n = 1'b1;
    tick();
    a.wr_valid = 1'b1; a.wr_data = 8'h74;
    tick();
    a.wr_valid = 1'b0;
    chk("mr_idle_wr_ready", a.wr_ready, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/norm_param_pingpong_buffer.md
# norm_param_pingpong_buffer

Double-buffered, lane-packed parameter store for the normalisation stage of the conv pipeline. It accepts a narrow per-channel parameter stream, packs `LANES` consecutive parameters into one wide entry, and writes it into the idle (fill) bank of two distributed RAMs. On commit the banks swap, so the next layer's parameters load while the current layer reads `LANES` channels per cycle through a registered read port.

## Interface

Parameters:
- `WIDTH`, 8: bits per parameter.
- `LANES`, 4: parameters packed per entry; read width is `WIDTH*LANES`.
- `ADDR_BITS`, 8: entry address width; each bank holds `2**ADDR_BITS` entries.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `load_start` in 1: begin (or restart) loading the fill bank.
- `wr_valid` in 1: `wr_data` valid.
- `wr_data` in `WIDTH`: parameter, channel order ascending.
- `wr_ready` out 1: buffer accepts `wr_data`; a word transfers when `wr_valid & wr_ready`.
- `load_commit` in 1: finish the load and swap banks.
- `rd_en` in 1: read request.
- `rd_addr` in `ADDR_BITS`: entry address in the active bank.
- `rd_data` out `WIDTH*LANES`: entry; lane 0 in bits `[WIDTH-1:0]`.
- `rd_valid` out 1: `rd_data` updated this cycle.
- `bank_ready` out 1: the active bank holds committed data.
- `load_count` out `ADDR_BITS+1`: entries committed in the active bank.

## Operation

- State machine: IDLE, FILL, FULL. Internal state: `active` bank bit (fill bank = `~active`), `lane_cnt`, `waddr` (`ADDR_BITS+1` bits), and a `WIDTH*(LANES-1)` pack register.
- IDLE: `wr_ready=0`. On `load_start`, go to FILL with `lane_cnt=0` and `waddr=0`. `load_commit` is ignored.
- FILL: `wr_ready=1`.
  - Each transfer places `wr_data` in lane `lane_cnt`, then increments `lane_cnt`.
  - On a transfer with `lane_cnt==LANES-1`, write {current word, pack register} to fill bank[`waddr`] in that cycle. Then `waddr++` and `lane_cnt=0`.
  - When `waddr` reaches `2**ADDR_BITS`, go to FULL.
- FULL: `wr_ready=0`. Waits for commit or restart.
- `load_commit` in FILL or FULL:
  - If `lane_cnt!=0`, flush a partial entry to fill bank[`waddr`] with unfilled lanes zero. A transfer in the same cycle is included in that entry.
  - Commit `load_count = waddr` plus 1 if a partial entry was flushed, toggle `active`, set `bank_ready=1`, go to IDLE.
  - Commit with zero words loaded is legal: `load_count=0`, banks still swap.
- `load_start` in FILL or FULL abandons the load: counters reset, the state is (re)entered as FILL, and the active bank is untouched. `load_start` has priority over a simultaneous `load_commit`.
- Read: on `rd_en`, `rd_data` is loaded from active bank[`rd_addr`] on the next edge and `rd_valid` is pulsed. Without `rd_en`, `rd_data` holds and `rd_valid=0`.
- The active bank is never written. Reads at `rd_addr >= load_count` return stale RAM contents; this is not an error.
- RAMs are distributed and are not reset.

## Timing

- Reset values: state IDLE, `active=0`, `wr_ready=0`, `rd_data=0`, `rd_valid=0`, `bank_ready=0`, `load_count=0`.
- Reset asserted mid-load discards the load.
- Read latency is 1 cycle: `rd_en` at edge N gives `rd_data`/`rd_valid` after edge N+1. Back-to-back reads sustain 1 entry per cycle.
- `wr_ready` is a registered state decode. It rises the cycle after `load_start` and falls the cycle after the final entry write.
- Swap: a read issued in the `load_commit` cycle uses the pre-swap bank. Reads from the next cycle on see the new bank.
- Write-to-read: a committed entry is readable from the cycle after commit.

## Test plan

- Reset then `rd_en` at addr 0: `rd_data=0` is not required (RAM not reset). Required: `rd_valid` pulses 1 cycle later; `bank_ready=0`; `load_count=0`; `wr_ready=0`.
- `LANES=4`: `load_start`, stream 0x01..0x08, commit. Then read addr 0,1: `0x04030201`, `0x08070605`; `load_count=2`; `bank_ready=1`.
- Stream 0x11,0x12,0x13, then commit in the same cycle as word 0x14 transfers. Then stream 0x21 only and commit. Expect `load_count=1` after each commit, and a read of addr 0 after the second commit returns `0x00000021`.
- Load bank B while continuously reading bank A at addr 0–1 every cycle: reads return A data through the commit cycle and B data from the next cycle; `rd_valid` never drops.
- `ADDR_BITS=2`: stream 20 words. `wr_ready` drops after word 16 and words 17–20 are not accepted; after commit `load_count=4`.
- `load_start` mid-FILL after 5 words, then 4 new words and commit: `load_count=1` with the new data. Separately, assert `rst_n` low mid-FILL: `bank_ready=0`, `wr_ready=0`.
